// File: rtl/tile_ram_arbiter_if.sv
// Tile RAM arbiter bus: video fetch, CPU request and RAM-side signals.
// slave = arbiter side, master = clients plus RAM.
interface tile_ram_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4
);
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] vid_data;
    logic              vid_valid;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_busy;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_err;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  vid_req, vid_addr,
        output vid_data, vid_valid,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_busy, cpu_ack, cpu_rdata, cpu_err,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output vid_req, vid_addr,
        input  vid_data, vid_valid,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_busy, cpu_ack, cpu_rdata, cpu_err,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/tile_ram_arbiter.sv
// Tile RAM arbiter: video fetch has absolute priority, CPU ops fill idle slots.
// Optional CPU wait timeout enabled by defining TILE_ARB_TIMEOUT_EN.
module tile_ram_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 4,
    parameter int MAX_WAIT = 1023
) (
    input logic clk,
    input logic rst,
    tile_ram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        PEND,
        RD_WAIT,
        ACK
    } state_t;

    state_t state, state_nx;

    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [1:0]        vpipe;
    logic              accept;
    logic              issue;

    logic [DATA_W-1:0] vid_data_q;
    logic              vid_valid_q;
    logic              busy_q;
    logic              ack_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic              ram_we_q;
    logic [DATA_W-1:0] ram_wdata_q;

`ifdef TILE_ARB_TIMEOUT_EN
    logic [9:0] wait_cnt;
    logic       timeout;
`endif

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        issue    = 1'b0;
`ifdef TILE_ARB_TIMEOUT_EN
        timeout  = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (bus.cpu_req) begin
                    accept   = 1'b1;
                    state_nx = PEND;
                end
            end
            PEND: begin
                if (!bus.vid_req) begin
                    issue    = 1'b1;
                    state_nx = lat_we ? ACK : RD_WAIT;
                end
`ifdef TILE_ARB_TIMEOUT_EN
                else if (wait_cnt == 10'(MAX_WAIT - 1)) begin
                    timeout  = 1'b1;
                    state_nx = IDLE;
                end
`endif
            end
            RD_WAIT: state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            vpipe       <= '0;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            vid_data_q  <= '0;
            vid_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
        end else begin
            state       <= state_nx;
            vpipe       <= {vpipe[0], bus.vid_req};
            vid_valid_q <= vpipe[1];
            if (vpipe[1])
                vid_data_q <= bus.ram_rdata;

            ram_we_q <= 1'b0;
            if (bus.vid_req) begin
                ram_addr_q <= bus.vid_addr;
            end else if (issue) begin
                ram_addr_q  <= lat_addr;
                ram_we_q    <= lat_we;
                ram_wdata_q <= lat_wdata;
            end

            if (accept) begin
                lat_we    <= bus.cpu_we;
                lat_addr  <= bus.cpu_addr;
                lat_wdata <= bus.cpu_wdata;
                busy_q    <= 1'b1;
            end

            ack_q <= 1'b0;
            err_q <= 1'b0;
            // Read data from the RAM lands while in ACK, so capture it with the ack.
            if (state == ACK) begin
                ack_q  <= 1'b1;
                busy_q <= 1'b0;
                if (!lat_we)
                    rdata_q <= bus.ram_rdata;
            end
`ifdef TILE_ARB_TIMEOUT_EN
            if (timeout) begin
                err_q  <= 1'b1;
                busy_q <= 1'b0;
            end
`endif
        end
    end

`ifdef TILE_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wait_cnt <= '0;
        else if (accept)
            wait_cnt <= '0;
        else if (state == PEND)
            wait_cnt <= wait_cnt + 10'd1;
    end
`endif

    assign bus.vid_data  = vid_data_q;
    assign bus.vid_valid = vid_valid_q;
    assign bus.cpu_busy  = busy_q;
    assign bus.cpu_ack   = ack_q;
    assign bus.cpu_rdata = rdata_q;
    assign bus.cpu_err   = err_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_wdata = ram_wdata_q;
endmodule
